// File: rtl/vault_alarm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vault_alarm_ctrl
// Purpose  : Vault alarm back-end. Grace-filters the raw alarm request,
//            latches the alarm, blinks the siren, checks the disarm code
//            with a wrong-code lockout, and shows a saturating event count
//            on a 7-segment display.
// Revision : 1.0 - initial release
// ============================================================================
module vault_alarm_ctrl #(
  parameter int          GRACE_CYCLES   = 4,
  parameter int          BLINK_HALF     = 2,
  parameter int          MAX_TRIES      = 3,
  parameter int          LOCKOUT_CYCLES = 8,
  parameter logic [3:0]  CODE           = 4'hA
) (
  input  logic       clk_2,
  input  logic       reset_n,
  input  logic       alarm_in,
  input  logic [3:0] code_in,
  input  logic       code_enter,
  output logic       siren,
  output logic       alarm_latched,
  output logic [1:0] state_o,
  output logic [3:0] event_count,
  output logic [1:0] tries,
  output logic [7:0] seg
);

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    PENDING = 2'd1,
    ALARM   = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  localparam int GW = $clog2(GRACE_CYCLES + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);

  localparam logic [GW-1:0] c_GRACE_LAST = GW'(GRACE_CYCLES - 1);
  localparam logic [BW-1:0] c_BLINK_LAST = BW'(BLINK_HALF - 1);
  localparam logic [LW-1:0] c_LOCK_LAST  = LW'(LOCKOUT_CYCLES - 1);
  localparam logic [1:0]    c_MAX_TRIES  = 2'(MAX_TRIES);

  state_t          state_q, state_d;
  logic [GW-1:0]   grace_q, grace_d;
  logic [BW-1:0]   blink_q, blink_d;
  logic [LW-1:0]   lock_q,  lock_d;
  logic            siren_q, siren_d;
  logic [1:0]      tries_q, tries_d;
  logic [3:0]      event_q, event_d;
  logic            enter_q;
  logic            press;
  logic            enter_alarm;

  assign press = code_enter & ~enter_q;

  // State register and counters; asynchronous active-low reset.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ARMED;
      grace_q <= '0;
      blink_q <= '0;
      lock_q  <= '0;
      siren_q <= 1'b0;
      tries_q <= 2'd0;
      event_q <= 4'd0;
      enter_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grace_q <= grace_d;
      blink_q <= blink_d;
      lock_q  <= lock_d;
      siren_q <= siren_d;
      tries_q <= tries_d;
      event_q <= event_d;
      enter_q <= code_enter;
    end
  end

  // Next-state logic: grace filter, blink timer, code checking, lockout.
  always_comb begin
    state_d     = state_q;
    grace_d     = grace_q;
    blink_d     = blink_q;
    lock_d      = lock_q;
    siren_d     = siren_q;
    tries_d     = tries_q;
    event_d     = event_q;
    enter_alarm = 1'b0;

    case (state_q)
      ARMED: begin
        if (alarm_in) begin
          if (GRACE_CYCLES == 1) begin
            enter_alarm = 1'b1;
          end else begin
            state_d = PENDING;
            grace_d = GW'(1);
          end
        end
      end
      PENDING: begin
        if (!alarm_in) begin
          state_d = ARMED;
          grace_d = '0;
        end else if (grace_q == c_GRACE_LAST) begin
          enter_alarm = 1'b1;
        end else begin
          grace_d = grace_q + 1'b1;
        end
      end
      ALARM: begin
        if (blink_q == c_BLINK_LAST) begin
          blink_d = '0;
          siren_d = ~siren_q;
        end else begin
          blink_d = blink_q + 1'b1;
        end
        // Correctness is checked first, so a good code can never also
        // trip the tries limit.
        if (press) begin
          if (code_in == CODE) begin
            state_d = ARMED;
            siren_d = 1'b0;
            tries_d = 2'd0;
            blink_d = '0;
          end else begin
            tries_d = tries_q + 2'd1;
            if ((tries_q + 2'd1) == c_MAX_TRIES) begin
              state_d = LOCKOUT;
              lock_d  = '0;
              siren_d = 1'b1;
            end
          end
        end
      end
      LOCKOUT: begin
        siren_d = 1'b1;
        if (lock_q == c_LOCK_LAST) begin
          state_d = ALARM;
          lock_d  = '0;
          tries_d = 2'd0;
          blink_d = '0;
        end else begin
          lock_d = lock_q + 1'b1;
        end
      end
      default: state_d = ARMED;
    endcase

    // A fresh alarm episode counts an event; a return from lockout does not.
    if (enter_alarm) begin
      state_d = ALARM;
      grace_d = '0;
      tries_d = 2'd0;
      blink_d = '0;
      siren_d = 1'b1;
      event_d = (event_q == 4'hF) ? event_q : event_q + 4'd1;
    end
  end

  // Hex digit decode of the event count, decimal point marks a latched alarm.
  always_comb begin
    seg = 8'h00;
    case (event_q)
      4'h0: seg[6:0] = 7'h3F;
      4'h1: seg[6:0] = 7'h06;
      4'h2: seg[6:0] = 7'h5B;
      4'h3: seg[6:0] = 7'h4F;
      4'h4: seg[6:0] = 7'h66;
      4'h5: seg[6:0] = 7'h6D;
      4'h6: seg[6:0] = 7'h7D;
      4'h7: seg[6:0] = 7'h07;
      4'h8: seg[6:0] = 7'h7F;
      4'h9: seg[6:0] = 7'h6F;
      4'hA: seg[6:0] = 7'h77;
      4'hB: seg[6:0] = 7'h7C;
      4'hC: seg[6:0] = 7'h39;
      4'hD: seg[6:0] = 7'h5E;
      4'hE: seg[6:0] = 7'h79;
      default: seg[6:0] = 7'h71;
    endcase
    seg[7] = alarm_latched;
  end

  assign alarm_latched = (state_q == ALARM) || (state_q == LOCKOUT);
  assign state_o       = state_q;
  assign siren         = siren_q;
  assign tries         = tries_q;
  assign event_count   = event_q;

endmodule
`default_nettype wire

// File: tb/tb_vault_alarm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vault_alarm_ctrl
// Purpose  : Directed self-checking bench for vault_alarm_ctrl with
//            hand-computed expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vault_alarm_ctrl;

  logic       clk_2 = 1'b0;
  logic       reset_n;
  logic       alarm_in;
  logic [3:0] code_in;
  logic       code_enter;
  logic       siren;
  logic       alarm_latched;
  logic [1:0] state_o;
  logic [3:0] event_count;
  logic [1:0] tries;
  logic [7:0] seg;

  int n_checks = 0;
  int n_fail   = 0;

  vault_alarm_ctrl dut (
    .clk_2        (clk_2),
    .reset_n      (reset_n),
    .alarm_in     (alarm_in),
    .code_in      (code_in),
    .code_enter   (code_enter),
    .siren        (siren),
    .alarm_latched(alarm_latched),
    .state_o      (state_o),
    .event_count  (event_count),
    .tries        (tries),
    .seg          (seg)
  );

  always #5 clk_2 = ~clk_2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One rising edge, then settle so sampling and driving are away from it.
  task automatic step();
    @(posedge clk_2);
    #1;
  endtask

  // Rising edge of code_enter on the next clock, then release for one clock.
  task automatic press_code(input logic [3:0] c);
    code_in    = c;
    code_enter = 1'b1;
    step();
    code_enter = 1'b0;
    step();
  endtask

  initial begin
    reset_n    = 1'b0;
    alarm_in   = 1'b0;
    code_in    = 4'h0;
    code_enter = 1'b0;
    #12;
    chk("rst_state", state_o, 0);
    chk("rst_siren", siren, 0);
    chk("rst_seg",   seg, 8'h3F);
    chk("rst_tries", tries, 0);
    reset_n = 1'b1;
    step();

    // 1: three-edge glitch is rejected
    alarm_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("glitch_pend", state_o, 1);
    end
    alarm_in = 1'b0;
    step();
    chk("glitch_armed", state_o, 0);
    chk("glitch_evt",   event_count, 0);
    chk("glitch_siren", siren, 0);
    chk("glitch_seg",   seg, 8'h3F);

    // 2: alarm latched on the fourth consecutive edge
    alarm_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("grace_pend", state_o, 1);
    end
    step();
    chk("alarm_state", state_o, 2);
    chk("alarm_evt",   event_count, 1);
    chk("alarm_siren", siren, 1);
    chk("alarm_seg",   seg, 8'h86);
    chk("alarm_latch", alarm_latched, 1);

    // 3: siren blinks with a 4-cycle period, alarm_in ignored
    alarm_in = 1'b0;
    begin
      logic [5:0] pat;
      pat = 6'b011001; // expected siren on edges 1..6 after entry, LSB first
      for (int i = 0; i < 6; i++) begin
        step();
        chk("blink_siren", siren, pat[i]);
        chk("blink_state", state_o, 2);
      end
    end

    // 4: three wrong codes -> lockout; a correct code there is ignored
    press_code(4'h3);
    chk("wrong1_tries", tries, 1);
    press_code(4'h3);
    chk("wrong2_tries", tries, 2);
    code_in    = 4'h3;
    code_enter = 1'b1;
    step();                               // lockout entry, lock=0
    chk("lock_state", state_o, 3);
    chk("lock_siren", siren, 1);
    chk("lock_tries", tries, 3);
    code_enter = 1'b0;
    step();                               // lock edge 1
    press_code(4'hA);                     // lock edges 2,3
    chk("lock_ignore", state_o, 3);
    for (int i = 4; i <= 7; i++) begin
      step();
      chk("lock_hold_state", state_o, 3);
      chk("lock_hold_siren", siren, 1);
    end
    step();                               // lock edge 8 -> back to ALARM
    chk("unlock_state", state_o, 2);
    chk("unlock_tries", tries, 0);
    chk("unlock_evt",   event_count, 1);
    chk("unlock_siren", siren, 1);

    // 5: held code_enter is one press; alarm_in still high restarts grace
    alarm_in   = 1'b1;
    code_in    = 4'hA;
    code_enter = 1'b1;
    step();
    chk("clear_state", state_o, 0);
    chk("clear_siren", siren, 0);
    chk("clear_dp",    seg[7], 0);
    step();
    chk("regrace_state", state_o, 1);
    step();
    step();
    step();
    chk("realarm_state", state_o, 2);
    chk("realarm_evt",   event_count, 2);
    alarm_in = 1'b0;
    step();                               // enter still held: no new press
    chk("held_no_press", state_o, 2);
    code_enter = 1'b0;
    step();
    press_code(4'hA);
    chk("clear2_state", state_o, 0);

    // 6: event count saturates at 15
    for (int k = 0; k < 14; k++) begin
      alarm_in = 1'b1;
      repeat (4) step();
      alarm_in = 1'b0;
      chk("sat_evt", event_count, (k + 3 > 15) ? 15 : k + 3);
      press_code(4'hA);
    end
    chk("sat_state", state_o, 0);
    chk("sat_seg",   seg, 8'h71);
    alarm_in = 1'b1;
    repeat (4) step();
    chk("sat_hold_evt", event_count, 15);
    chk("sat_alarm_seg", seg, 8'hF1);

    // asynchronous reset mid-ALARM, checked before any clock edge
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_state", state_o, 0);
    chk("async_siren", siren, 0);
    chk("async_evt",   event_count, 0);
    chk("async_tries", tries, 0);
    chk("async_seg",   seg, 8'h3F);
    alarm_in = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    chk("post_rst_state", state_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vault_alarm_ctrl.md
Name: vault_alarm_ctrl

Overview:
Sequential back-end for the bank-vault alarm. It consumes the raw combinational alarm request (door open AND (key absent OR time-lock active)) produced by the board top level. It filters the request with a grace period, latches the alarm, and drives a blinking siren. It requires a 4-bit code to clear, locks out after repeated wrong codes, and shows a saturating event count on the 7-segment display.

Parameters:
GRACE_CYCLES, 4, consecutive clk_2 edges alarm_in must stay high before latching (>=1)
BLINK_HALF, 2, siren half-period in clk_2 cycles while in ALARM (>=1)
MAX_TRIES, 3, wrong codes accepted before LOCKOUT (1..3)
LOCKOUT_CYCLES, 8, clk_2 cycles spent in LOCKOUT (>=1)
CODE, 4'hA, disarm code

Ports:
clk_2  input  1  system clock; all state changes on its rising edge
reset_n  input  1  asynchronous, active-low reset
alarm_in  input  1  raw alarm request from top-level combinational logic
code_in  input  4  code value from switches
code_enter  input  1  level from switch/button; only its rising edge counts as a submission
siren  output  1  siren/LED drive
alarm_latched  output  1  1 while state is ALARM or LOCKOUT
state_o  output  2  ARMED=0, PENDING=1, ALARM=2, LOCKOUT=3
event_count  output  4  number of ALARM entries; saturates at 15
tries  output  2  wrong codes entered in the current ALARM episode
seg  output  8  {dp,g,f,e,d,c,b,a}, active-high; hex digit of event_count; dp = alarm_latched

Behaviour:
- Reset (reset_n=0, asynchronous, also mid-operation):
  - state=ARMED; grace, blink and lockout counters = 0.
  - siren=0, tries=0, event_count=0, code_enter edge register=0.
  - seg=8'h3F.
- Code edge: press = code_enter & ~enter_q, where enter_q is code_enter registered every cycle in every state. Presses are evaluated only in ALARM; they are discarded in all other states.
- ARMED:
  - alarm_in=1 and GRACE_CYCLES=1 -> ALARM.
  - alarm_in=1 and GRACE_CYCLES>1 -> PENDING with grace=1.
  - Otherwise stay.
- PENDING:
  - alarm_in=0 -> ARMED with grace=0 (glitch rejected, no event).
  - grace==GRACE_CYCLES-1 -> ALARM.
  - Otherwise grace++.
  - Net effect: ALARM is entered on the GRACE_CYCLES-th consecutive edge with alarm_in=1.
- Entry to ALARM from ARMED or PENDING:
  - event_count = min(event_count+1, 15).
  - tries=0, blink=0, siren=1.
- ALARM:
  - blink++ each cycle; when blink==BLINK_HALF-1, toggle siren and set blink=0.
  - Correct press (code_in==CODE) -> ARMED next edge with siren=0, tries=0. This happens even if alarm_in is still 1; in that case the grace filter restarts on the following edge.
  - Wrong press -> tries++; if the new tries==MAX_TRIES -> LOCKOUT with lock=0.
  - alarm_in is ignored in ALARM.
- LOCKOUT:
  - siren held steady at 1; all presses ignored; lock++ each cycle.
  - When lock==LOCKOUT_CYCLES-1 -> ALARM with tries=0, blink=0, siren=1.
  - event_count is NOT incremented on this return.
- A correct press and a tries-limit on the same edge cannot occur: one press per edge, and correctness is checked first.
- All outputs are registered except seg and alarm_latched. Those two are combinational from registered state/event_count, so there is zero added latency.
- seg digit map (0-F), active-high:
  - 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
  - Bit 7 is OR-ed with alarm_latched.

Test Plan:
1. Reset, then alarm_in=1 for 3 edges, then 0 -> state goes 1,1,1, then 0; event_count=0; siren=0; seg=8'h3F.
2. alarm_in=1 for 4 edges -> state_o=2 on the 4th edge; event_count=1; siren=1; seg=8'h86.
3. Continue in ALARM, then release alarm_in -> siren follows 1,1,0,0,1,1 with period 4 cycles; state stays 2.
4. In ALARM, code_in=4'h3 pressed 3 times, then held 8 cycles -> tries goes 1,2, then state=3 with siren steady 1. After 8 cycles state=2, tries=0, event_count still 1. A code_in=4'hA press during LOCKOUT has no effect.
5. In ALARM, code_in=4'hA with code_enter held high for 5 cycles -> exactly one press; state=0; siren=0; dp=0. With alarm_in still 1, state=1 on the next edge.
6. Trigger 16 separate alarms (each cleared with 4'hA) -> event_count saturates at 15 (seg=8'h71 while armed). Assert reset_n=0 mid-ALARM -> all outputs reset immediately without a clock edge.
